// File: rtl/io_trap_ctrl_pkg.sv
// io_trap_pkg: shared types and constants for the I/O trap sequencer.
//   trap_state_e : trap sequencer states (3-bit encoding)
//   DIR_IN/DIR_OUT : io_direction encoding from the opcode tracker
//   NMI_CNT_W    : width of the NMI pulse-width counter (NMI_PULSE <= 15)
//   port_match() : masked port compare
package io_trap_pkg;

    typedef enum logic [2:0] {
        USER  = 3'd0,
        HOLD  = 3'd1,
        NMI   = 3'd2,
        ACK   = 3'd3,
        SUPER = 3'd4,
        EXIT  = 3'd5
    } trap_state_e;

    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

    localparam int unsigned NMI_CNT_W = 4;

    function automatic logic port_match(input logic [7:0] port,
                                        input logic [7:0] base,
                                        input logic [7:0] mask);
        return (port & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/io_trap_ctrl_if.sv
// io_trap_ctrl_if: Z80 bus signals seen by the trap controller.
//   iorq_n, m1_n, wr_n : bus strobes (asynchronous to clk)
//   addr_lo, data_in   : A7..A0 and D7..D0
//   nmi_n              : NMI back to the CPU, active low
// master = CPU side, slave = trap controller.
interface io_trap_ctrl_if;
    logic       iorq_n;
    logic       m1_n;
    logic       wr_n;
    logic [7:0] addr_lo;
    logic [7:0] data_in;
    logic       nmi_n;

    modport master (output iorq_n, m1_n, wr_n, addr_lo, data_in, input nmi_n);
    modport slave  (input iorq_n, m1_n, wr_n, addr_lo, data_in, output nmi_n);
endinterface

// File: rtl/io_trap_ctrl_bus_sync.sv
// bus_sync: WIDTH-bit 2-flop synchroniser with edge detect.
//   clk, rst_n : clock, asynchronous active-low reset (presets all flops to 1)
//   async_in   : asynchronous inputs
//   sync_out   : synchronised levels
//   rise, fall : one-clk pulses on synchronised rising/falling edges
module bus_sync #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
            prev_q <= '1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/io_trap_ctrl.sv
// io_trap_ctrl: I/O virtualisation trap sequencer for the Nabu MegaMapper.
// Blocks matching user-mode port accesses, latches them, raises NMI, and
// returns to user mode after the supervisor's RETN.
//   clk, reset_n     : clock, asynchronous active-low reset
//   bus (slave)      : iorq_n, m1_n, wr_n, addr_lo, data_in in; nmi_n out
//   new_isr, last_isr_untrap, io_direction : from the opcode tracker
//   trap_en          : global trap enable
//   ignore_next_isr  : to the opcode tracker, high across the NMI acknowledge
//   io_block         : suppresses the real peripheral decode
//   trap_port/trap_data/trap_dir : latched access details
//   super_mode       : 1 while in supervisor (trapping inhibited)
//   trap_count       : only with `define TRAP_COUNT_EN; saturating trap count
module io_trap_ctrl
    import io_trap_pkg::*;
#(
    parameter logic [7:0]  TRAP_BASE = 8'h00,
    parameter logic [7:0]  TRAP_MASK = 8'hF0,
    parameter int unsigned NMI_PULSE = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    io_trap_ctrl_if.slave   bus,
    input  logic            new_isr,
    input  logic            last_isr_untrap,
    input  logic            io_direction,
    input  logic            trap_en,
    output logic            ignore_next_isr,
    output logic            io_block,
    output logic [7:0]      trap_port,
    output logic [7:0]      trap_data,
    output logic            trap_dir,
    output logic            super_mode
`ifdef TRAP_COUNT_EN
    ,
    output logic [15:0]     trap_count
`endif
);

    // Bit order in the synchroniser: [2]=iorq_n, [1]=m1_n, [0]=wr_n
    logic [2:0] sync_lvl, sync_rise, sync_fall;

    bus_sync #(.WIDTH(3)) u_sync (
        .clk      (clk),
        .rst_n    (reset_n),
        .async_in ({bus.iorq_n, bus.m1_n, bus.wr_n}),
        .sync_out (sync_lvl),
        .rise     (sync_rise),
        .fall     (sync_fall)
    );

    logic sync_unused;
    assign sync_unused = &{sync_lvl[2], sync_lvl[0], sync_rise[0], sync_fall[0]};

    logic iorq_fall, iorq_rise, m1_rise, m1_fall, m1_high;
    assign iorq_fall = sync_fall[2];
    assign iorq_rise = sync_rise[2];
    assign m1_rise   = sync_rise[1];
    assign m1_fall   = sync_fall[1];
    assign m1_high   = sync_lvl[1];

    // IORQ with M1 low is an interrupt acknowledge, never a port access
    logic io_cycle;
    assign io_cycle = iorq_fall & m1_high;

    trap_state_e          state_q, state_d;
    logic                 nmi_q, nmi_d;
    logic                 ign_q, ign_d;
    logic                 blk_q, blk_d;
    logic                 sup_q, sup_d;
    logic [NMI_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]           port_q, port_d;
    logic [7:0]           data_q, data_d;
    logic                 dir_q, dir_d;
    logic                 trap_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= USER;
            nmi_q   <= 1'b1;
            ign_q   <= 1'b0;
            blk_q   <= 1'b0;
            sup_q   <= 1'b0;
            cnt_q   <= '0;
            port_q  <= '0;
            data_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nmi_q   <= nmi_d;
            ign_q   <= ign_d;
            blk_q   <= blk_d;
            sup_q   <= sup_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nmi_d    = nmi_q;
        ign_d    = ign_q;
        blk_d    = blk_q;
        sup_d    = sup_q;
        cnt_d    = cnt_q;
        port_d   = port_q;
        data_d   = data_q;
        dir_d    = dir_q;
        trap_hit = 1'b0;

        case (state_q)
            USER: begin
                if (io_cycle && trap_en && port_match(bus.addr_lo, TRAP_BASE, TRAP_MASK)) begin
                    trap_hit = 1'b1;
                    port_d   = bus.addr_lo;
                    dir_d    = io_direction;
                    if (io_direction == DIR_OUT)
                        data_d = bus.data_in;
                    blk_d    = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (iorq_rise) begin
                    blk_d   = 1'b0;
                    nmi_d   = 1'b0;
                    ign_d   = 1'b1;
                    cnt_d   = NMI_CNT_W'(NMI_PULSE - 1);
                    state_d = NMI;
                end
            end
            NMI: begin
                // nmi_n went low on entry; NMI_PULSE-1 decrements plus the
                // release cycle give exactly NMI_PULSE low cycles
                if (cnt_q == '0) begin
                    nmi_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                if (m1_rise) begin
                    ign_d   = 1'b0;
                    sup_d   = 1'b1;
                    state_d = SUPER;
                end
            end
            SUPER: begin
                if (last_isr_untrap)
                    state_d = EXIT;
            end
            EXIT: begin
                if (m1_fall && new_isr) begin
                    sup_d   = 1'b0;
                    state_d = USER;
                end
            end
            default: state_d = USER;
        endcase
    end

    assign bus.nmi_n       = nmi_q;
    assign ignore_next_isr = ign_q;
    assign io_block        = blk_q;
    assign super_mode      = sup_q;
    assign trap_port       = port_q;
    assign trap_data       = data_q;
    assign trap_dir        = dir_q;

`ifdef TRAP_COUNT_EN
    logic [15:0] trap_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            trap_count_q <= '0;
        else if (trap_hit && (trap_count_q != '1))
            trap_count_q <= trap_count_q + 16'd1;
    end

    assign trap_count = trap_count_q;
`else
    logic trap_hit_unused;
    assign trap_hit_unused = trap_hit;
`endif

endmodule

// File: tb/tb_io_trap_ctrl.sv
// Directed bench for io_trap_ctrl (default parameters: base 0x00, mask 0xF0,
// 4-cycle NMI). Counter checks are built only with TRAP_COUNT_EN.
module tb_io_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        new_isr, last_isr_untrap, io_direction, trap_en;
    logic        ignore_next_isr, io_block, trap_dir, super_mode;
    logic [7:0]  trap_port, trap_data;
`ifdef TRAP_COUNT_EN
    logic [15:0] trap_count;
`endif

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    io_trap_ctrl_if bus ();

    io_trap_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
        .new_isr         (new_isr),
        .last_isr_untrap (last_isr_untrap),
        .io_direction    (io_direction),
        .trap_en         (trap_en),
        .ignore_next_isr (ignore_next_isr),
        .io_block        (io_block),
        .trap_port       (trap_port),
        .trap_data       (trap_data),
        .trap_dir        (trap_dir),
        .super_mode      (super_mode)
`ifdef TRAP_COUNT_EN
        ,
        .trap_count      (trap_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One I/O cycle: IORQ low for 5 clks, then 3 clks after release so a
    // trap has just entered NMI on return.
    task automatic io_access(input logic [7:0] a, input logic [7:0] d,
                             input logic dir, output logic saw_blk);
        bus.addr_lo  = a;
        bus.data_in  = d;
        io_direction = dir;
        bus.wr_n     = dir;
        bus.iorq_n   = 1'b0;
        saw_blk      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            saw_blk |= io_block;
        end
        bus.iorq_n = 1'b1;
        bus.wr_n   = 1'b1;
        step(3);
    endtask

    task automatic ack_to_super(input string tag);
        int k = 0;
        while (bus.nmi_n === 1'b0 && k < 40) begin
            step(1);
            k++;
        end
        check_val({tag, "_nmi_rel"}, bus.nmi_n, 1);
        bus.m1_n = 1'b0;
        step(3);
        bus.m1_n = 1'b1;
        step(3);
        check_val({tag, "_super"}, super_mode, 1);
    endtask

    task automatic exit_super(input string tag);
        last_isr_untrap = 1'b1;
        step(1);
        last_isr_untrap = 1'b0;
        new_isr  = 1'b1;
        bus.m1_n = 1'b0;
        step(3);
        check_val({tag, "_user"}, super_mode, 0);
        bus.m1_n = 1'b1;
        new_isr  = 1'b0;
        step(3);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        int   low_cnt;

        reset_n = 1'b0;
        bus.iorq_n = 1'b1; bus.m1_n = 1'b1; bus.wr_n = 1'b1;
        bus.addr_lo = 8'h00; bus.data_in = 8'h00;
        new_isr = 1'b0; last_isr_untrap = 1'b0; io_direction = 1'b0; trap_en = 1'b0;
        step(2);
        check_val("rst_nmi",   bus.nmi_n, 1);
        check_val("rst_ign",   ignore_next_isr, 0);
        check_val("rst_blk",   io_block, 0);
        check_val("rst_super", super_mode, 0);
        check_val("rst_port",  trap_port, 0);
        check_val("rst_data",  trap_data, 0);
        check_val("rst_dir",   trap_dir, 0);
        reset_n = 1'b1;
        step(2);

        // 1: OUT (0x05),A with A=0x3C
        trap_en = 1'b1;
        bus.addr_lo = 8'h05; bus.data_in = 8'h3C; io_direction = 1'b0; bus.wr_n = 1'b0;
        bus.iorq_n = 1'b0;
        step(2);
        check_val("t1_blk_pre", io_block, 0);
        step(1);
        check_val("t1_blk",  io_block, 1);
        check_val("t1_port", trap_port, 8'h05);
        check_val("t1_dir",  trap_dir, 0);
        check_val("t1_data", trap_data, 8'h3C);
        check_val("t1_nmi_hold", bus.nmi_n, 1);
        step(3);
        check_val("t1_blk_held", io_block, 1);
        bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
        step(2);
        check_val("t1_blk_sync", io_block, 1);
        step(1);
        check_val("t1_blk_off", io_block, 0);
        check_val("t1_nmi_on",  bus.nmi_n, 0);
        check_val("t1_ign_on",  ignore_next_isr, 1);
        low_cnt = 0;
        while (bus.nmi_n === 1'b0 && low_cnt < 40) begin
            low_cnt++;
            step(1);
        end
        check_val("t1_nmi_width", 16'(low_cnt), 4);
        check_val("t1_ign_ack", ignore_next_isr, 1);
        bus.m1_n = 1'b0;
        step(3);
        check_val("t1_super_wait", super_mode, 0);
        bus.m1_n = 1'b1;
        step(3);
        check_val("t1_super", super_mode, 1);
        check_val("t1_ign_off", ignore_next_isr, 0);

        // 3: no trapping in SUPER; exit needs untrap then new_isr M1
        io_access(8'h02, 8'h77, 1'b0, saw);
        check_val("t3_sup_blk",  saw, 0);
        check_val("t3_sup_nmi",  bus.nmi_n, 1);
        check_val("t3_sup_port", trap_port, 8'h05);
        new_isr = 1'b1; bus.m1_n = 1'b0;
        step(3);
        bus.m1_n = 1'b1; new_isr = 1'b0;
        step(3);
        check_val("t3_no_untrap", super_mode, 1);
        exit_super("t3");
        io_access(8'h02, 8'hA5, 1'b0, saw);
        check_val("t3_retrap_blk",  saw, 1);
        check_val("t3_retrap_port", trap_port, 8'h02);
        check_val("t3_retrap_data", trap_data, 8'hA5);
        check_val("t3_retrap_nmi",  bus.nmi_n, 0);
        ack_to_super("t3");
        exit_super("t3b");

        // 2: IN A,(0x41) does not match
        io_access(8'h41, 8'h00, 1'b1, saw);
        check_val("t2_blk",   saw, 0);
        check_val("t2_nmi",   bus.nmi_n, 1);
        check_val("t2_super", super_mode, 0);
        check_val("t2_port",  trap_port, 8'h02);

        // matching IN: direction latched, data held from the last OUT
        io_access(8'h0A, 8'hEE, 1'b1, saw);
        check_val("in_blk",  saw, 1);
        check_val("in_port", trap_port, 8'h0A);
        check_val("in_dir",  trap_dir, 1);
        check_val("in_data", trap_data, 8'hA5);
        ack_to_super("in");
        exit_super("in");

        // trap_en low: matching port ignored
        trap_en = 1'b0;
        io_access(8'h03, 8'h99, 1'b0, saw);
        check_val("den_blk", saw, 0);
        check_val("den_nmi", bus.nmi_n, 1);
        trap_en = 1'b1;

        // 4: interrupt acknowledge with addr 0x00
        bus.m1_n = 1'b0;
        step(1);
        bus.addr_lo = 8'h00;
        bus.iorq_n  = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            saw |= io_block;
        end
        bus.iorq_n = 1'b1; bus.m1_n = 1'b1;
        step(6);
        check_val("t4_blk",   saw, 0);
        check_val("t4_nmi",   bus.nmi_n, 1);
        check_val("t4_super", super_mode, 0);

        // 5: reset in the second NMI cycle
        io_access(8'h0F, 8'h11, 1'b0, saw);
        check_val("t5_nmi_on", bus.nmi_n, 0);
        step(1);
        reset_n = 1'b0;
        #1;
        check_val("t5_rst_nmi",   bus.nmi_n, 1);
        check_val("t5_rst_ign",   ignore_next_isr, 0);
        check_val("t5_rst_blk",   io_block, 0);
        check_val("t5_rst_super", super_mode, 0);
        check_val("t5_rst_port",  trap_port, 0);
        check_val("t5_rst_data",  trap_data, 0);
        step(2);
        reset_n = 1'b1;
        step(2);
        io_access(8'h07, 8'h5A, 1'b0, saw);
        check_val("t5_post_blk",  saw, 1);
        check_val("t5_post_port", trap_port, 8'h07);
        check_val("t5_post_data", trap_data, 8'h5A);
        ack_to_super("t5");
        exit_super("t5");

`ifdef TRAP_COUNT_EN
        // 6: one trap since reset, two more make three, then saturation
        check_val("t6_cnt1", trap_count, 16'd1);
        for (int i = 0; i < 2; i++) begin
            io_access(8'h01, 8'h00, 1'b0, saw);
            ack_to_super("t6");
            exit_super("t6");
        end
        check_val("t6_cnt3", trap_count, 16'd3);
        force dut.trap_count_q = 16'hFFFF;
        #1;
        release dut.trap_count_q;
        io_access(8'h01, 8'h00, 1'b0, saw);
        check_val("t6_sat", trap_count, 16'hFFFF);
        ack_to_super("t6s");
        exit_super("t6s");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/io_trap_ctrl.md
Name: io_trap_ctrl

Overview:
- Sequences the I/O virtualisation trap for the Nabu MegaMapper CPLD.
- Consumes the opcode tracker's instruction-boundary, RETN-untrap and I/O-direction outputs together with synchronised Z80 bus strobes.
- Blocks matching user-mode port accesses, latches the access details, and raises NMI to enter the supervisor.
- Returns to user mode after the supervisor's RETN completes, and drives ignore_next_isr back into the opcode tracker across the NMI acknowledge.

Parameters:
- TRAP_BASE, 8'h00, port base compared after masking.
- TRAP_MASK, 8'hF0, port bits that take part in the compare.
- NMI_PULSE, 4, NMI low width in clk cycles, legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- iorq_n  in  1  Z80 IORQ, asynchronous.
- m1_n  in  1  Z80 M1, asynchronous.
- wr_n  in  1  Z80 WR, asynchronous.
- addr_lo  in  8  Z80 A7..A0.
- data_in  in  8  Z80 data bus.
- new_isr  in  1  from opcode tracker; the next M1 starts a new instruction.
- last_isr_untrap  in  1  from opcode tracker; the last opcode completed was ED 45 (RETN).
- io_direction  in  1  from opcode tracker; 1 = IN, 0 = OUT.
- trap_en  in  1  global trap enable.
- nmi_n  out  1  NMI to the CPU, active low.
- ignore_next_isr  out  1  to opcode tracker.
- io_block  out  1  suppresses the decode of the real peripheral.
- trap_port  out  8  latched port number.
- trap_data  out  8  latched OUT data.
- trap_dir  out  1  latched direction.
- super_mode  out  1  1 = supervisor (trapping inhibited).

Behaviour:
- Strobes pass through a 2-flop synchroniser; edges are detected on the synchronised copies. Sampled addr_lo, data_in and io_direction are qualified by the synchronised strobe.
- I/O cycle = synchronised iorq_n falling while synchronised m1_n is high. iorq_n low with m1_n low is an interrupt acknowledge and is never trapped.
- Port match: (addr_lo & TRAP_MASK) == (TRAP_BASE & TRAP_MASK).
- States:
  - USER: on an I/O cycle with trap_en=1 and a port match, in the same clk:
    - trap_port <= addr_lo;
    - trap_dir <= io_direction;
    - if io_direction=0, trap_data <= data_in (data is held, since the trap is detected while IORQ is active);
    - io_block <= 1;
    - go to HOLD.
    - Non-matching I/O, or trap_en=0: no action.
  - HOLD: io_block stays 1 until synchronised iorq_n rises, then io_block <= 0, nmi_n <= 0, counter loaded, go to NMI.
  - NMI: nmi_n held low for exactly NMI_PULSE cycles, then released. ignore_next_isr <= 1 on entry. Go to ACK.
  - ACK: waits for synchronised m1_n rising, which ends the NMI acknowledge M1. Then ignore_next_isr <= 0, super_mode <= 1, go to SUPER.
  - SUPER: trapping inhibited. When last_isr_untrap is seen high (held at least 1 clk), go to EXIT.
  - EXIT: on the next synchronised m1_n falling edge with new_isr=1 (first user opcode fetch), super_mode <= 0, go to USER.
- Latches (trap_port, trap_dir, trap_data) hold their values until the next trap.
- trap_en falling outside USER has no effect; the sequence completes.
- trap_en rising mid-cycle: only the next I/O cycle edge is evaluated.
- Simultaneous events: a USER trap detect and a last_isr_untrap pulse cannot conflict, because untrap is only acted on in SUPER. last_isr_untrap in any other state is ignored.
- Reset, asynchronous at any point, including mid-NMI:
  - state USER;
  - nmi_n=1, ignore_next_isr=0, io_block=0, super_mode=0;
  - trap_port=0, trap_data=0, trap_dir=0;
  - synchronisers preset to 1 (strobes idle).

Optional Feature:
- TRAP_COUNT_EN defined:
  - adds output trap_count[15:0], reset to 0;
  - increments on each USER->HOLD transition;
  - saturates at 16'hFFFF.
- Undefined: port absent, no counter logic.

Decomposition:
- Package io_trap_pkg:
  - state enum (USER, HOLD, NMI, ACK, SUPER, EXIT), 3-bit encoding;
  - DIR_IN=1, DIR_OUT=0;
  - NMI counter width constant.
- Sub-module bus_sync:
  - parameterised-width 2-flop synchroniser;
  - outputs synchronised level plus rise and fall pulses;
  - instantiated once for {iorq_n, m1_n, wr_n}.

Test Plan:
1. OUT (0x05),A with A=0x3C, trap_en=1 -> trap_port=0x05, trap_dir=0, trap_data=0x3C. io_block high from detect until iorq_n rise. nmi_n low exactly 4 clk, then super_mode=1 after the ack M1 completes.
2. IN A,(0x41) with trap_en=1 -> no match, so no io_block and no NMI; state stays USER.
3. In SUPER, OUT (0x02) -> no trap. Then pulse last_isr_untrap, then M1 fall with new_isr=1 -> super_mode=0. A following OUT (0x02) traps again.
4. Interrupt acknowledge (m1_n and iorq_n both low) with addr_lo=0x00 -> no trap.
5. Assert reset_n low during NMI (cycle 2) -> nmi_n=1, state USER immediately. After release, the next matching I/O traps normally.
6. With TRAP_COUNT_EN defined: 3 traps -> trap_count=3. Force count to 16'hFFFF then trap -> count stays 16'hFFFF.
